// File: rtl/axi_hdr_pkg.sv
// Shared FSM encoding and default sizing for the AXI-stream header arbiter.
package axi_hdr_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam int DEF_DATA_WD = 32;
   localparam int DEF_N_CH    = 4;
endpackage

// File: rtl/axi_stream_header_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int GW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [GW-1:0]   last_grant,
   output logic [N_CH-1:0] grant_oh,
   output logic [GW-1:0]   grant_bin
);
   logic [GW-1:0] idx_s;
   logic          hit_s;
   logic          found_s;

   // Rotating-priority search starting one above the previous winner.
   always_comb begin
      grant_oh  = '0;
      grant_bin = '0;
      found_s   = 1'b0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
         idx_s           = GW'((int'(last_grant) + i) % N_CH);
         hit_s           = req[idx_s] & ~found_s;
         grant_oh[idx_s] = hit_s;
         grant_bin       = hit_s ? idx_s : grant_bin;
         found_s         = found_s | hit_s;
      end
   end
endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Arbitrates N_CH header+payload sources onto one insert-header port pair.
module axi_stream_header_arbiter
   import axi_hdr_pkg::*;
#(
   parameter int  DATA_WD = DEF_DATA_WD,
   parameter int  N_CH    = DEF_N_CH,
   localparam int KW      = DATA_WD / 8,
   localparam int CW      = $clog2(DATA_WD / 8),
   localparam int GW      = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      s_valid_insert,
   input  logic [N_CH*DATA_WD-1:0] s_data_insert,
   input  logic [N_CH*KW-1:0]   s_keep_insert,
   input  logic [N_CH*CW-1:0]   s_byte_insert_cnt,
   output logic [N_CH-1:0]      s_ready_insert,
   input  logic [N_CH-1:0]      s_valid_in,
   input  logic [N_CH-1:0]      s_last_in,
   input  logic [N_CH*DATA_WD-1:0] s_data_in,
   input  logic [N_CH*KW-1:0]   s_keep_in,
   output logic [N_CH-1:0]      s_ready_in,
   output logic                 m_valid_insert,
   output logic [DATA_WD-1:0]   m_data_insert,
   output logic [KW-1:0]        m_keep_insert,
   output logic [CW-1:0]        m_byte_insert_cnt,
   input  logic                 m_ready_insert,
   output logic                 m_valid_in,
   output logic [DATA_WD-1:0]   m_data_in,
   output logic [KW-1:0]        m_keep_in,
   output logic                 m_last_in,
   input  logic                 m_ready_in,
   output logic [GW-1:0]        grant_id,
   output logic                 busy
);
   state_e              state_r;
   logic [GW-1:0]       grant_r;
   logic [GW-1:0]       last_grant_r;
   logic [N_CH-1:0]     arb_oh_s;
   logic [GW-1:0]       arb_bin_s;

   logic [DATA_WD-1:0]  hdr_data_a [N_CH];
   logic [KW-1:0]       hdr_keep_a [N_CH];
   logic [CW-1:0]       hdr_cnt_a  [N_CH];
   logic [DATA_WD-1:0]  pay_data_a [N_CH];
   logic [KW-1:0]       pay_keep_a [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign hdr_data_a[k] = s_data_insert[k*DATA_WD +: DATA_WD];
      assign hdr_keep_a[k] = s_keep_insert[k*KW +: KW];
      assign hdr_cnt_a[k]  = s_byte_insert_cnt[k*CW +: CW];
      assign pay_data_a[k] = s_data_in[k*DATA_WD +: DATA_WD];
      assign pay_keep_a[k] = s_keep_in[k*KW +: KW];
   end

   rr_arbiter #(.N_CH(N_CH), .GW(GW)) u_rr_arbiter (
      .req        (s_valid_insert),
      .last_grant (last_grant_r),
      .grant_oh   (arb_oh_s),
      .grant_bin  (arb_bin_s)
   );

   assign busy     = (state_r != ST_IDLE);
   assign grant_id = grant_r;

   // Output steering from the registered grant; only the granted lane sees ready.
   always_comb begin
      m_valid_insert    = 1'b0;
      m_valid_in        = 1'b0;
      m_last_in         = 1'b0;
      s_ready_insert    = '0;
      s_ready_in        = '0;
      m_data_insert     = hdr_data_a[grant_r];
      m_keep_insert     = hdr_keep_a[grant_r];
      m_byte_insert_cnt = hdr_cnt_a[grant_r];
      m_data_in         = pay_data_a[grant_r];
      m_keep_in         = pay_keep_a[grant_r];
      case (state_r)
         ST_HDR: begin
            m_valid_insert          = s_valid_insert[grant_r];
            s_ready_insert[grant_r] = m_ready_insert;
         end
         ST_DATA: begin
            m_valid_in          = s_valid_in[grant_r];
            m_last_in           = s_last_in[grant_r];
            s_ready_in[grant_r] = m_ready_in;
         end
         default: begin
            m_valid_insert = 1'b0;
            m_valid_in     = 1'b0;
         end
      endcase
   end

   // Packet FSM: grant is latched in IDLE and held until the last payload beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         grant_r      <= '0;
         last_grant_r <= GW'(N_CH - 1);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|arb_oh_s) begin
                  grant_r <= arb_bin_s;
                  state_r <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (m_valid_insert && m_ready_insert) begin
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (m_valid_in && m_ready_in && m_last_in) begin
                  state_r      <= ST_IDLE;
                  last_grant_r <= grant_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Randomised bench for axi_stream_header_arbiter against a packet-level reference model.
module tb_axi_stream_header_arbiter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   s_valid_insert;
   logic [127:0] s_data_insert;
   logic [15:0]  s_keep_insert;
   logic [7:0]   s_byte_insert_cnt;
   logic [3:0]   s_ready_insert;
   logic [3:0]   s_valid_in, s_last_in;
   logic [127:0] s_data_in;
   logic [15:0]  s_keep_in;
   logic [3:0]   s_ready_in;
   logic         m_valid_insert;
   logic [31:0]  m_data_insert;
   logic [3:0]   m_keep_insert;
   logic [1:0]   m_byte_insert_cnt;
   logic         m_ready_insert;
   logic         m_valid_in;
   logic [31:0]  m_data_in;
   logic [3:0]   m_keep_in;
   logic         m_last_in;
   logic         m_ready_in;
   logic [1:0]   grant_id;
   logic         busy;

   axi_stream_header_arbiter #(.DATA_WD(32), .N_CH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
      .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
      .s_ready_insert(s_ready_insert),
      .s_valid_in(s_valid_in), .s_last_in(s_last_in), .s_data_in(s_data_in),
      .s_keep_in(s_keep_in), .s_ready_in(s_ready_in),
      .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
      .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
      .m_ready_insert(m_ready_insert),
      .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
      .m_last_in(m_last_in), .m_ready_in(m_ready_in),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] d; logic [3:0] k; logic [1:0] c;} hdr_t;
   typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;

   hdr_t        hdr_q  [4][$];
   beat_t       beat_q [4][$];
   logic [31:0] recv_q [$];
   int          gnt_log[$];
   int          checks = 0;
   int          errors = 0;
   int          nbeats = 0;
   int          ph = 0;      // model phase: 0 idle, 1 header, 2 payload
   int          mg = 0;      // model grant
   int          ml = 3;      // model last grant
   bit          gaps = 1'b0;
   bit          rand_ready = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic add_pkt(input int ch, input logic [31:0] h, input logic [1:0] c,
                          input int n, input logic [31:0] base);
      hdr_t  hh;
      beat_t bb;
      hh = '{d: h, k: 4'hF, c: c};
      hdr_q[ch].push_back(hh);
      for (int i = 0; i < n; i++) begin
         bb = '{d: base + 32'(i), k: 4'hF, l: (i == n - 1)};
         beat_q[ch].push_back(bb);
      end
   endtask

   function automatic bit drained();
      for (int ch = 0; ch < 4; ch++)
         if (hdr_q[ch].size() != 0 || beat_q[ch].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive();
      for (int ch = 0; ch < 4; ch++) begin
         if (hdr_q[ch].size() > 0) begin
            s_valid_insert[ch]             = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data_insert[ch*32 +: 32]     = hdr_q[ch][0].d;
            s_keep_insert[ch*4 +: 4]       = hdr_q[ch][0].k;
            s_byte_insert_cnt[ch*2 +: 2]   = hdr_q[ch][0].c;
         end else begin
            s_valid_insert[ch]             = 1'b0;
            s_data_insert[ch*32 +: 32]     = $urandom;
            s_keep_insert[ch*4 +: 4]       = 4'h0;
            s_byte_insert_cnt[ch*2 +: 2]   = 2'd0;
         end
         if (beat_q[ch].size() > 0) begin
            s_valid_in[ch]             = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data_in[ch*32 +: 32]     = beat_q[ch][0].d;
            s_keep_in[ch*4 +: 4]       = beat_q[ch][0].k;
            s_last_in[ch]              = beat_q[ch][0].l;
         end else begin
            s_valid_in[ch]             = 1'b0;
            s_data_in[ch*32 +: 32]     = $urandom;
            s_keep_in[ch*4 +: 4]       = 4'h0;
            s_last_in[ch]              = 1'b0;
         end
      end
      m_ready_insert = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready_in     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   // Compare DUT against the model, then advance sources, sink log and model by one edge.
   task automatic compare_update();
      logic       exp_mvi, exp_mvd;
      logic [3:0] exp_ri, exp_rd;
      bit         found;
      int         c;
      exp_mvi = (ph == 1) && s_valid_insert[mg];
      exp_mvd = (ph == 2) && s_valid_in[mg];
      exp_ri  = (ph == 1 && m_ready_insert) ? 4'(1 << mg) : 4'h0;
      exp_rd  = (ph == 2 && m_ready_in) ? 4'(1 << mg) : 4'h0;
      chk("busy", busy, ph != 0);
      if (ph != 0) chk("grant_id", grant_id, mg);
      chk("m_valid_insert", m_valid_insert, exp_mvi);
      chk("s_ready_insert", s_ready_insert, exp_ri);
      chk("m_valid_in", m_valid_in, exp_mvd);
      chk("s_ready_in", s_ready_in, exp_rd);
      if (exp_mvi) begin
         chk("m_data_insert", m_data_insert, s_data_insert[mg*32 +: 32]);
         chk("m_keep_insert", m_keep_insert, s_keep_insert[mg*4 +: 4]);
         chk("m_byte_insert_cnt", m_byte_insert_cnt, s_byte_insert_cnt[mg*2 +: 2]);
      end
      if (exp_mvd) begin
         chk("m_data_in", m_data_in, s_data_in[mg*32 +: 32]);
         chk("m_keep_in", m_keep_in, s_keep_in[mg*4 +: 4]);
         chk("m_last_in", m_last_in, s_last_in[mg]);
      end
      if (m_valid_insert && m_ready_insert) begin
         recv_q.push_back(m_data_insert);
         gnt_log.push_back(int'(grant_id));
      end
      if (m_valid_in && m_ready_in) begin
         recv_q.push_back(m_data_in);
         nbeats++;
      end
      for (int ch = 0; ch < 4; ch++) begin
         if (s_valid_insert[ch] && s_ready_insert[ch] && hdr_q[ch].size() > 0)
            void'(hdr_q[ch].pop_front());
         if (s_valid_in[ch] && s_ready_in[ch] && beat_q[ch].size() > 0)
            void'(beat_q[ch].pop_front());
      end
      case (ph)
         0: begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               c = (ml + k) % 4;
               if (!found && s_valid_insert[c]) begin
                  mg    = c;
                  found = 1'b1;
               end
            end
            if (found) ph = 1;
         end
         1: if (exp_mvi && m_ready_insert) ph = 2;
         2: if (exp_mvd && m_ready_in && s_last_in[mg]) begin
               ph = 0;
               ml = mg;
            end
         default: ph = 0;
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      compare_update();
   endtask

   task automatic run_until_idle(input string nm, input int maxc);
      int n = 0;
      while (!(drained() && ph == 0) && n < maxc) begin
         cycle();
         n++;
      end
      chk(nm, n < maxc, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_grant_id"}, grant_id, 2'd0);
      chk({nm, "_m_valid_insert"}, m_valid_insert, 1'b0);
      chk({nm, "_m_valid_in"}, m_valid_in, 1'b0);
      chk({nm, "_s_ready_insert"}, s_ready_insert, 4'h0);
      chk({nm, "_s_ready_in"}, s_ready_in, 4'h0);
   endtask

   initial begin
      int nb0, n, nbusy, total;
      logic [31:0] exp_w;
      rst_n = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // All four channels request together: strict 0,1,2,3 order, each header once.
      for (int ch = 0; ch < 4; ch++)
         add_pkt(ch, 32'hC0DE_0000 + 32'(ch), 2'(ch), 2, 32'(ch + 1) << 12);
      run_until_idle("t1_timeout", 200);
      chk("t1_grants", gnt_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_grant_order", gnt_log[i], i);
      chk("t1_words", recv_q.size(), 12);
      for (int ch = 0; ch < 4; ch++) begin
         exp_w = 32'hC0DE_0000 + 32'(ch);
         chk("t1_hdr", recv_q[ch*3], exp_w);
         exp_w = (32'(ch + 1) << 12);
         chk("t1_beat0", recv_q[ch*3 + 1], exp_w);
         chk("t1_beat1", recv_q[ch*3 + 2], exp_w + 32'd1);
      end

      // Channel 2 alone, known words; busy drops one cycle after last handshake.
      recv_q.delete(); gnt_log.delete();
      add_pkt(2, 32'hA5A5_A5A5, 2'd1, 4, 32'h10);
      n = 0;
      while (recv_q.size() < 5 && n < 50) begin cycle(); n++; end
      chk("t2_timeout", n < 50, 1'b1);
      chk("t2_busy_at_last", busy, 1'b1);
      cycle();
      chk("t2_busy_after_last", busy, 1'b0);
      chk("t2_hdr", recv_q[0], 32'hA5A5_A5A5);
      for (int i = 0; i < 4; i++) chk("t2_beat", recv_q[i + 1], 32'h10 + 32'(i));

      // 6-beat packet under random downstream ready and source gaps.
      recv_q.delete(); gnt_log.delete();
      gaps = 1'b1; rand_ready = 1'b1;
      add_pkt(1, 32'h1111_0006, 2'd3, 6, 32'h60);
      run_until_idle("t3_timeout", 300);
      chk("t3_words", recv_q.size(), 7);
      chk("t3_hdr", recv_q[0], 32'h1111_0006);
      for (int i = 0; i < 6; i++) chk("t3_beat", recv_q[i + 1], 32'h60 + 32'(i));

      // Channel 1 busy; 0 and 2 join mid-packet; 2 must win next.
      recv_q.delete(); gnt_log.delete();
      gaps = 1'b0; rand_ready = 1'b0;
      add_pkt(1, 32'h2222_0001, 2'd0, 4, 32'h70);
      n = 0;
      while (ph != 2 && n < 20) begin cycle(); n++; end
      chk("t4_enter_data", ph, 2);
      add_pkt(0, 32'h2222_0000, 2'd0, 1, 32'h80);
      add_pkt(2, 32'h2222_0002, 2'd0, 1, 32'h90);
      run_until_idle("t4_timeout", 100);
      chk("t4_grants", gnt_log.size(), 3);
      chk("t4_first", gnt_log[0], 1);
      chk("t4_second", gnt_log[1], 2);
      chk("t4_third", gnt_log[2], 0);

      // Asynchronous reset during payload beat 3 of channel 3.
      recv_q.delete(); gnt_log.delete();
      add_pkt(3, 32'h3333_0003, 2'd2, 6, 32'h30);
      nb0 = nbeats; n = 0;
      while (nbeats - nb0 < 2 && n < 50) begin cycle(); n++; end
      chk("t5_two_beats", nbeats - nb0, 2);
      @(posedge clk);
      #1;
      drive();
      #2;
      chk("t5_grant_before_reset", grant_id, 2'd3);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t5_async");
      for (int ch = 0; ch < 4; ch++) begin
         hdr_q[ch].delete();
         beat_q[ch].delete();
      end
      drive();
      ph = 0; mg = 0; ml = 3;
      recv_q.delete(); gnt_log.delete();
      @(negedge clk);
      rst_n = 1'b1;
      add_pkt(2, 32'h4444_0002, 2'd0, 1, 32'hA0);
      add_pkt(0, 32'h4444_0000, 2'd0, 1, 32'hB0);
      run_until_idle("t5_timeout", 100);
      chk("t5_grants", gnt_log.size(), 2);
      chk("t5_first_after_reset", gnt_log[0], 0);
      chk("t5_second_after_reset", gnt_log[1], 2);

      // Single-beat packet: exactly two busy cycles (HDR, DATA).
      recv_q.delete(); gnt_log.delete();
      add_pkt(1, 32'h5555_0001, 2'd1, 1, 32'hC0);
      nbusy = 0; n = 0;
      while (!(drained() && ph == 0) && n < 20) begin
         cycle();
         if (busy) nbusy++;
         n++;
      end
      cycle();
      chk("t6_busy_cycles", nbusy, 2);
      chk("t6_idle_after", busy, 1'b0);
      chk("t6_words", recv_q.size(), 2);
      chk("t6_beat", recv_q[1], 32'hC0);

      // Random traffic on all channels with gaps and random back-pressure.
      recv_q.delete(); gnt_log.delete();
      gaps = 1'b1; rand_ready = 1'b1;
      total = 0;
      for (int p = 0; p < 40; p++) begin
         n = $urandom_range(1, 5);
         add_pkt($urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)), n, $urandom);
         total += n;
      end
      nb0 = nbeats;
      run_until_idle("t7_timeout", 4000);
      chk("t7_beats", nbeats - nb0, total);
      chk("t7_headers", gnt_log.size(), 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_stream_header_arbiter.md
AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, bus width in bits; multiple of 8, at least 16.
REQ-002 Parameter N_CH, default 4, number of source channels, range 2..8.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_valid_insert  in  N_CH  per-channel header valid.
REQ-006 s_data_insert  in  N_CH*DATA_WD  per-channel header word; channel k in slice k.
REQ-007 s_keep_insert  in  N_CH*DATA_WD/8  per-channel header byte keep.
REQ-008 s_byte_insert_cnt  in  N_CH*clog2(DATA_WD/8)  per-channel header byte count.
REQ-009 s_ready_insert  out  N_CH  per-channel header ready.
REQ-010 s_valid_in, s_last_in  in  N_CH each  per-channel data valid and last beat.
REQ-011 s_data_in  in  N_CH*DATA_WD; s_keep_in  in  N_CH*DATA_WD/8  per-channel payload and byte keep.
REQ-012 s_ready_in  out  N_CH  per-channel data ready.
REQ-013 m_valid_insert out 1, m_data_insert out DATA_WD, m_keep_insert out DATA_WD/8, m_byte_insert_cnt out clog2(DATA_WD/8), m_ready_insert in 1  header port toward the insert-header block.
REQ-014 m_valid_in out 1, m_data_in out DATA_WD, m_keep_in out DATA_WD/8, m_last_in out 1, m_ready_in in 1  data port toward the insert-header block.
REQ-015 grant_id  out  clog2(N_CH)  currently granted channel.
REQ-016 busy  out  1  high in HDR or DATA.

Function
REQ-017 FSM states IDLE, HDR, DATA.
REQ-018 IDLE: all m_ valids 0, all s_ readies 0; when any s_valid_insert bit is high, register the winner into grant_id and go to HDR next cycle.
REQ-019 Winner selection: round-robin, first requesting channel searching from last_grant+1 upward, modulo N_CH.
REQ-020 HDR: m_*_insert = granted channel's header fields, combinational mux; s_ready_insert[grant_id] = m_ready_insert; all other readies 0.
REQ-021 HDR: on m_valid_insert and m_ready_insert both high go to DATA; otherwise hold, grant unchanged even if the requester drops valid.
REQ-022 DATA: m_*_in = granted channel's data fields; s_ready_in[grant_id] = m_ready_in; all other readies 0; gaps in source valid pass through unchanged.
REQ-023 DATA: handshake with m_last_in high goes to IDLE; last_grant <= grant_id in the same cycle.
REQ-024 Single-beat packets (last on first beat) are legal; IDLE -> HDR -> DATA -> IDLE minimum 3 cycles per packet.
REQ-025 Data beats presented by any channel before its header handshake stall; no data is forwarded in IDLE or HDR.
REQ-026 Non-granted channels see ready 0 in every state; requests may arrive or drop at any time without affecting the current grant.

Reset
REQ-027 Reset: state IDLE, grant_id 0, busy 0, all m_ valids 0, all s_ readies 0, last_grant N_CH-1, so channel 0 wins first.
REQ-028 Reset asserted mid-packet aborts the packet; no partial-packet recovery after release.

Structure
REQ-029 Package axi_hdr_pkg holds the state encoding and default DATA_WD and N_CH constants.
REQ-030 One sub-module, rr_arbiter: request vector and last_grant in, one-hot and binary grant out, purely combinational.
REQ-031 Output muxes are combinational from the registered grant_id; only state, grant_id and last_grant are registered.

Verification
REQ-032 Channels 0..3 request together, each sends 2 beats, ready held 1 -> grant order 0,1,2,3; each header is m_data_insert for exactly one handshake.
REQ-033 Channel 2 only, header 0xA5A5A5A5, byte_insert_cnt 1, 4 beats 0x10..0x13, keep 0x0F on last -> identical words on the m_ ports; busy falls 1 cycle after the last handshake.
REQ-034 m_ready_in toggles randomly during a 6-beat packet -> no beat lost or duplicated; s_ready_in follows m_ready_in for the granted channel only.
REQ-035 Channel 1 granted mid-packet, channel 0 requests -> channel 0 waits; after channel 1's last beat, channel 2 (if requesting) beats channel 0.
REQ-036 rst_n pulled low during DATA beat 3 -> all outputs return to reset values asynchronously; after release, channel 0 is granted first.
REQ-037 Single-beat packet, last on first beat -> IDLE, HDR, DATA, IDLE in 3 cycles with m_last_in high on the only beat.
